// File: rtl/morph_pkg.sv
// morph_pkg: operation codes, frame FSM states and config helpers shared by
// the morphology frame controller and its position counter.
package morph_pkg;

    typedef logic [1:0] morph_op_t;

    localparam morph_op_t MORPH_BYPASS = 2'b00;
    localparam morph_op_t MORPH_ERODE  = 2'b01;
    localparam morph_op_t MORPH_DILATE = 2'b10;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // The unused code 2'b11 is never allowed to reach the kernels.
    function automatic morph_op_t coerce_op(input morph_op_t op);
        return (op == 2'b11) ? MORPH_BYPASS : op;
    endfunction

endpackage

// File: rtl/morph_pos_cnt.sv
// morph_pos_cnt: saturating pixel/line position counters, border flags for
// the 3x3 window taps, and the sticky frame geometry error.
module morph_pos_cnt #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             active,
    input  logic             href,
    input  logic             clken,
    input  logic             hr_fall,
    input  logic             vs_fall,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [3:0]       border,
    output logic             size_err
);

    localparam logic [CNT_W-1:0] W  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] H  = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] W1 = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] H1 = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0] x_cnt, y_cnt, y_nxt;
    logic             pix, line_end, frame_end, x_full, y_full, err_set;

    // A line ending in the same cycle as vsync falls must be counted before
    // the frame height is judged, hence the check against y_nxt.
    always_comb begin
        pix       = active & href & clken;
        line_end  = active & hr_fall;
        frame_end = active & vs_fall;
        x_full    = (x_cnt == W);
        y_full    = (y_cnt == H);
        y_nxt     = (line_end && !y_full) ? y_cnt + CNT_W'(1) : y_cnt;
        err_set   = (pix & x_full) | (line_end & (!x_full | y_full)) | (frame_end & (y_nxt != H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            size_err <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            border   <= 4'b0;
        end else begin
            if (start) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                size_err <= 1'b0;
            end else begin
                x_cnt    <= line_end ? '0 : (pix && !x_full) ? x_cnt + CNT_W'(1) : x_cnt;
                y_cnt    <= y_nxt;
                size_err <= size_err | err_set;
            end
            border <= pix ? {y_cnt == '0, y_cnt == H1, x_cnt == '0, x_cnt == W1} : 4'b0;
            if (pix) begin
                pix_x <= x_cnt;
                pix_y <= y_cnt;
            end
        end
    end

endmodule

// File: rtl/morph_frame_ctrl.sv
// morph_frame_ctrl: frame sequencer for the morphology chain; applies shadowed
// stage operations only at frame start and reports frame completion.
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_op_a,
    input  logic [1:0]       cfg_op_b,
    output logic             cfg_pending,
    output logic [1:0]       op_a,
    output logic [1:0]       op_b,
    output logic             ctrl_href,
    output logic             ctrl_clken,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [3:0]       border,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             size_err,
    output logic             busy
);

    logic       vs_d, hr_d, vs_rise, vs_fall, hr_fall, start, active;
    logic [1:0] state, state_nxt;
    morph_op_t  sh_a, sh_b;

    always_comb begin
        vs_rise   = per_frame_vsync & ~vs_d;
        vs_fall   = ~per_frame_vsync & vs_d;
        hr_fall   = ~per_frame_href & hr_d;
        start     = vs_rise && (state == IDLE);
        active    = (state == ACTIVE);
        state_nxt = (state == IDLE)   ? (vs_rise ? ACTIVE : IDLE) :
                    (state == ACTIVE) ? (vs_fall ? DONE : ACTIVE) : IDLE;
    end

    // Edge detectors reset high so a reset released mid-frame sees no rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= 1'b1;
            hr_d        <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            ctrl_href   <= 1'b0;
            ctrl_clken  <= 1'b0;
            sh_a        <= MORPH_BYPASS;
            sh_b        <= MORPH_BYPASS;
            op_a        <= MORPH_BYPASS;
            op_b        <= MORPH_BYPASS;
            cfg_pending <= 1'b0;
        end else begin
            vs_d       <= per_frame_vsync;
            hr_d       <= per_frame_href;
            state      <= state_nxt;
            busy       <= (state_nxt == ACTIVE);
            frame_done <= (state == DONE);
            frame_cnt  <= (state == DONE) ? frame_cnt + CNT_W'(1) : frame_cnt;
            ctrl_href  <= per_frame_href;
            ctrl_clken <= per_frame_clken;
            if (cfg_wr) begin
                sh_a <= coerce_op(cfg_op_a);
                sh_b <= coerce_op(cfg_op_b);
            end
            if (start) begin
                op_a <= sh_a;
                op_b <= sh_b;
            end
            cfg_pending <= cfg_wr ? 1'b1 : start ? 1'b0 : cfg_pending;
        end
    end

    morph_pos_cnt #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CNT_W(CNT_W)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .active  (active),
        .href    (per_frame_href),
        .clken   (per_frame_clken),
        .hr_fall (hr_fall),
        .vs_fall (vs_fall),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .border  (border),
        .size_err(size_err)
    );

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// tb_morph_frame_ctrl: randomized frames on a 4x3 image checked against a
// frame-level model of positions, borders, op application and geometry errors.
module tb_morph_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 12;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          vsync = 1'b0, href = 1'b0, clken = 1'b0, cfg_wr = 1'b0;
    logic [1:0]    cfg_op_a = 2'b0, cfg_op_b = 2'b0;
    logic          cfg_pending, ctrl_href, ctrl_clken, frame_done, size_err, busy;
    logic [1:0]    op_a, op_b;
    logic [CW-1:0] pix_x, pix_y, frame_cnt;
    logic [3:0]    border;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [3:0]    b;
    } px_t;

    px_t        exp_q[$];
    px_t        mon_e;
    int         total = 0, bad = 0, done_n = 0, exp_frames = 0;
    int         lens[8];
    logic [1:0] sh_a = 2'b0, sh_b = 2'b0, ex_a = 2'b0, ex_b = 2'b0;
    bit         ex_pend = 1'b0, mon_en = 1'b0;

    morph_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .per_frame_vsync(vsync),
        .per_frame_href (href),
        .per_frame_clken(clken),
        .cfg_wr         (cfg_wr),
        .cfg_op_a       (cfg_op_a),
        .cfg_op_b       (cfg_op_b),
        .cfg_pending    (cfg_pending),
        .op_a           (op_a),
        .op_b           (op_b),
        .ctrl_href      (ctrl_href),
        .ctrl_clken     (ctrl_clken),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .border         (border),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .size_err       (size_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] coerce(input logic [1:0] op);
        return (op == 2'b11) ? 2'b00 : op;
    endfunction

    function automatic px_t mk_px(input int p, input int l);
        px_t r;
        int  x, y;
        x   = (p < W) ? p : W;
        y   = (l < H) ? l : H;
        r.x = CW'(x);
        r.y = CW'(y);
        r.b = {y == 0, y == H - 1, x == 0, x == W - 1};
        return r;
    endfunction

    always @(negedge clk) begin
        if (frame_done) done_n++;
        if (rst_n && mon_en) begin
            if (ctrl_clken && ctrl_href) begin
                if (exp_q.size() == 0) check("pix_extra", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("pix_x", int'(pix_x), int'(mon_e.x));
                    check("pix_y", int'(pix_y), int'(mon_e.y));
                    check("border", int'(border), int'(mon_e.b));
                end
            end else check("border_idle", int'(border), 0);
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_op_a"}, int'(op_a), 0);
        check({tag, "_op_b"}, int'(op_b), 0);
        check({tag, "_pend"}, int'(cfg_pending), 0);
        check({tag, "_chref"}, int'(ctrl_href), 0);
        check({tag, "_cclken"}, int'(ctrl_clken), 0);
        check({tag, "_px"}, int'(pix_x), 0);
        check({tag, "_py"}, int'(pix_y), 0);
        check({tag, "_border"}, int'(border), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_fcnt"}, int'(frame_cnt), 0);
        check({tag, "_err"}, int'(size_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [1:0] b);
        cfg_op_a = a;
        cfg_op_b = b;
        cfg_wr   = 1'b1;
        tick;
        cfg_wr   = 1'b0;
        sh_a     = coerce(a);
        sh_b     = coerce(b);
        ex_pend  = 1'b1;
    endtask

    task automatic send_frame(input int nl, input bit wr_rise, input bit wr_mid);
        logic [1:0] na, nb;
        bit         err;
        int         base;
        mon_en = 1'b1;
        na     = 2'($urandom);
        nb     = 2'($urandom);
        vsync  = 1'b1;
        if (wr_rise) begin
            cfg_op_a = na;
            cfg_op_b = nb;
            cfg_wr   = 1'b1;
        end
        tick;
        cfg_wr  = 1'b0;
        ex_a    = sh_a;
        ex_b    = sh_b;
        ex_pend = wr_rise;
        if (wr_rise) begin
            sh_a = coerce(na);
            sh_b = coerce(nb);
        end
        @(negedge clk);
        check("start_op_a", int'(op_a), int'(ex_a));
        check("start_op_b", int'(op_b), int'(ex_b));
        check("start_pend", int'(cfg_pending), int'(ex_pend));
        check("start_busy", int'(busy), 1);
        check("start_err", int'(size_err), 0);
        err = 1'b0;
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            for (int p = 0; p < lens[l]; p++) begin
                repeat ($urandom_range(0, 2)) tick;
                clken = 1'b1;
                exp_q.push_back(mk_px(p, l));
                tick;
                clken = 1'b0;
            end
            href  = 1'b0;
            clken = 1'($urandom_range(0, 1));
            tick;
            clken = 1'b0;
            tick;
            err |= (lens[l] != W) || (l >= H);
            @(negedge clk);
            check("err_line", int'(size_err), int'(err));
            if (wr_mid && l == 0) begin
                cfg_write(2'($urandom), 2'($urandom));
                @(negedge clk);
                check("mid_pend", int'(cfg_pending), 1);
                check("mid_op_a", int'(op_a), int'(ex_a));
                check("mid_op_b", int'(op_b), int'(ex_b));
            end
        end
        base  = done_n;
        vsync = 1'b0;
        repeat (4) tick;
        err |= (nl != H);
        exp_frames++;
        @(negedge clk);
        check("done_pulses", done_n - base, 1);
        check("frame_cnt", int'(frame_cnt), exp_frames);
        check("end_err", int'(size_err), int'(err));
        check("end_busy", int'(busy), 0);
        check("q_empty", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic reset_mid_line;
        int base;
        vsync = 1'b1;
        tick;
        tick;
        href  = 1'b1;
        clken = 1'b1;
        repeat (3) tick;
        rst_n = 1'b0;
        #2;
        check_reset("rst_mid");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        sh_a       = 2'b0;
        sh_b       = 2'b0;
        ex_pend    = 1'b0;
        exp_frames = 0;
        base       = done_n;
        repeat (3) tick;
        clken = 1'b0;
        href  = 1'b0;
        tick;
        tick;
        vsync = 1'b0;
        repeat (5) tick;
        @(negedge clk);
        check("orphan_done", done_n - base, 0);
        check("orphan_fcnt", int'(frame_cnt), 0);
        check("orphan_busy", int'(busy), 0);
        check("orphan_px", int'(pix_x), 0);
        check("orphan_py", int'(pix_y), 0);
        check("orphan_err", int'(size_err), 0);
        check("orphan_pend", int'(cfg_pending), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        tick;
        foreach (lens[i]) lens[i] = W;

        cfg_write(2'b01, 2'b10);
        @(negedge clk);
        check("idle_pend", int'(cfg_pending), 1);
        check("idle_op_a", int'(op_a), 0);
        send_frame(H, 1'b0, 1'b0);
        send_frame(H, 1'b0, 1'b1);
        send_frame(H, 1'b1, 1'b0);
        send_frame(H, 1'b0, 1'b0);

        lens[0] = 3;
        send_frame(H, 1'b0, 1'b0);
        lens[0] = W;

        cfg_write(2'b11, 2'b11);
        send_frame(H, 1'b0, 1'b0);

        reset_mid_line;
        send_frame(H, 1'b0, 1'b0);

        for (int f = 0; f < 16; f++) begin
            int r, nl;
            r  = int'($urandom_range(0, 5));
            nl = (r == 0) ? H - 1 : (r == 1) ? H + 1 : H;
            for (int l = 0; l < 8; l++) begin
                r       = int'($urandom_range(0, 9));
                lens[l] = (r == 0) ? W - 1 : (r == 1) ? W + 1 : W;
            end
            if ($urandom_range(0, 2) == 0) cfg_write(2'($urandom), 2'($urandom));
            send_frame(nl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morph_frame_ctrl.md
# morph_frame_ctrl

Frame-level sequencer for the binary morphology chain (3x3 erosion/dilation kernels fed by the 3x3 shift-RAM window). It latches per-frame operation selects for two cascaded kernel stages at frame boundaries only, so a mid-frame configuration write never changes a frame in flight. It also tracks pixel and line position, generating the border flags the kernels use to mask window taps outside the image. It reports frame completion and geometry errors. It sits beside the kernels, driven by the same `per_frame_*` timing signals.

## Interface
- `IMG_W`, default 640: active pixels per line.
- `IMG_H`, default 480: active lines per frame.
- `CNT_W`, default 12: width of the position and frame counters.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous active-low reset.
- `per_frame_vsync` in 1: frame valid, high for the whole frame.
- `per_frame_href` in 1: line valid.
- `per_frame_clken` in 1: pixel strobe.
- `cfg_wr` in 1: single-cycle configuration write strobe.
- `cfg_op_a` in 2: stage A operation.
- `cfg_op_b` in 2: stage B operation.
- `cfg_pending` out 1: a written configuration is not yet applied.
- `op_a` out 2: active stage A operation for the current frame.
- `op_b` out 2: active stage B operation for the current frame.
- `ctrl_href` out 1: `per_frame_href` delayed 1 cycle.
- `ctrl_clken` out 1: `per_frame_clken` delayed 1 cycle.
- `pix_x` out CNT_W: column index of the pixel on `ctrl_clken`.
- `pix_y` out CNT_W: line index of the pixel on `ctrl_clken`.
- `border` out 4: {top, bottom, left, right}, qualified by `ctrl_clken`.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_cnt` out CNT_W: completed frames, wraps.
- `size_err` out 1: sticky geometry mismatch in the current or last frame.
- `busy` out 1: FSM in ACTIVE.

## Operation
- Operation encoding: 00 bypass, 01 erode, 10 dilate. On write, the reserved code 11 is coerced to 00.
- Shadow register: `cfg_wr` loads the shadow and sets `cfg_pending`.
- Apply point: on the vsync rising edge, the shadow is copied to `op_a`/`op_b` and `cfg_pending` clears.
- `cfg_wr` in the same cycle as the vsync rise: the rise applies the old shadow; the new value loads the shadow; `cfg_pending` stays 1.
- FSM states:
  - IDLE → ACTIVE on vsync rise.
  - ACTIVE → DONE on vsync fall.
  - DONE → IDLE unconditionally.
- In DONE: `frame_done` = 1 and `frame_cnt` increments (wraps at 2^CNT_W).
- Counting occurs only in ACTIVE:
  - The pixel counter increments on `href & clken` and clears on href fall.
  - The line counter increments on href fall and clears on vsync rise.
- Border flags are computed from the pre-increment counts:
  - top = (y == 0)
  - bottom = (y == IMG_H-1)
  - left = (x == 0)
  - right = (x == IMG_W-1)
- `size_err`:
  - Set on href fall if the pixel count ≠ IMG_W.
  - Set on vsync fall if the line count ≠ IMG_H.
  - Clears on the next vsync rise.
- Counters saturate at IMG_W / IMG_H. `size_err` is set on saturation overflow, and the counters do not wrap.

## Timing
- Reset values:
  - `op_a`, `op_b` = 00.
  - `cfg_pending`, `ctrl_*`, `border`, `frame_done`, `size_err`, `busy` = 0.
  - `pix_x`, `pix_y`, `frame_cnt` = 0.
  - FSM = IDLE.
- Vsync/href edge-detect registers reset to 1. If reset releases mid-frame or mid-line, no edge is seen and the partial frame is ignored until the next rise.
- All outputs are registered. Position and border outputs have 1-cycle latency and are aligned with `ctrl_clken`.
- `op_a`/`op_b` change in the cycle after the vsync rise, before the first href of the frame.
- `frame_done` is asserted in the cycle 2 clocks after the vsync fall is sampled.
- `clken` without `href` is ignored. `href` outside ACTIVE is ignored.

## Structure
- Shared package `morph_pkg`:
  - `MORPH_BYPASS` = 2'b00, `MORPH_ERODE` = 2'b01, `MORPH_DILATE` = 2'b10.
  - FSM state constants IDLE, ACTIVE, DONE.
- One sub-module, `morph_pos_cnt`: the pixel/line counters, saturation, and border-flag generation.
- The FSM and config shadow stay in the top.

## Test plan
- Reset, then config write op_a = 01, op_b = 10 while idle:
  - `cfg_pending` = 1.
  - At the next vsync rise, `op_a` = 01 and `op_b` = 10 one cycle later.
  - `cfg_pending` = 0.
- Config write mid-frame:
  - `op_*` unchanged until the following frame's vsync rise.
  - `cfg_wr` coincident with the vsync rise leaves the old ops and `cfg_pending` = 1.
- 4x3 frame (IMG_W = 4, IMG_H = 3):
  - `border` = 1010 at (0,0), 0101 at (3,2), 0000 at (1,1).
  - `frame_done` pulses once; `frame_cnt` = 1.
  - `size_err` = 0.
- Short line (3 pixels with IMG_W = 4): `size_err` = 1 after href fall, held until the next vsync rise.
- `rst_n` pulsed low mid-line with vsync high:
  - All outputs return to their reset values.
  - No counting and no `frame_done` until a fresh vsync rise.
- Write of reserved op 11: the applied op = 00.
